// File: rtl/prbs4_pkg.sv
// Shared types and constants for the 4-bit PRBS generator/checker pair.
package prbs4_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs4_state_e;

  localparam logic [3:0] PRBS4_SEED   = 4'h2;
  localparam int         LOCK_CNT_DEF = 4;
  localparam int         LOSS_CNT_DEF = 3;

endpackage

// File: rtl/lfsr4_next.sv
// Combinational step of the 4-bit LFSR: shift left, feed back s[3]^s[1].
module lfsr4_next (
  input  logic [3:0] cur,
  output logic [3:0] nxt
);

  assign nxt = {cur[2:0], cur[3] ^ cur[1]};

endmodule

// File: rtl/prbs4_checker.sv
// PRBS4 receive checker: seeds from the incoming stream, locks after LOCK_CNT
// correct transitions, then flywheels and counts mismatched words.
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int LOSS_CNT = LOSS_CNT_DEF,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

  prbs4_state_e     state_r, state_n;
  logic [3:0]       ref_r, ref_n;
  logic             seed_r, seed_n;
  logic [3:0]       match_r, match_n;
  logic [3:0]       miss_r, miss_n;
  logic             locked_r;
  logic             err_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic [3:0]       ref_f_s;
  logic             mis_s;
  logic             hit_s;

  lfsr4_next u_next (
    .cur(ref_r),
    .nxt(ref_f_s)
  );

  // Next-state for FSM, reference, seed flag and run counters.
  always_comb begin
    state_n = state_r;
    ref_n   = ref_r;
    seed_n  = seed_r;
    match_n = match_r;
    miss_n  = miss_r;
    mis_s   = 1'b0;
    hit_s   = 1'b0;
    if (valid_i) begin
      case (state_r)
        SEARCH: begin
          hit_s  = seed_r && (data_i == ref_f_s) && (data_i != 4'h0);
          ref_n  = data_i;
          seed_n = (data_i != 4'h0);
          if (hit_s) begin
            if ((match_r + 4'd1) == LOCK_TGT) begin
              state_n = LOCKED;
              match_n = 4'd0;
            end else begin
              match_n = match_r + 4'd1;
            end
          end else begin
            match_n = 4'd0;
          end
        end
        LOCKED: begin
          ref_n = ref_f_s;
          if (data_i != ref_f_s) begin
            mis_s = 1'b1;
            // Losing lock reseeds from the offending word.
            if ((miss_r + 4'd1) == LOSS_TGT) begin
              state_n = SEARCH;
              ref_n   = data_i;
              seed_n  = (data_i != 4'h0);
              miss_n  = 4'd0;
              match_n = 4'd0;
            end else begin
              miss_n = miss_r + 4'd1;
            end
          end else begin
            miss_n = 4'd0;
          end
        end
        default: begin
          state_n = SEARCH;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= SEARCH;
      ref_r     <= 4'h0;
      seed_r    <= 1'b0;
      match_r   <= 4'd0;
      miss_r    <= 4'd0;
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= ERR_ZERO;
    end else begin
      state_r  <= state_n;
      ref_r    <= ref_n;
      seed_r   <= seed_n;
      match_r  <= match_n;
      miss_r   <= miss_n;
      locked_r <= (state_n == LOCKED);
      err_r    <= mis_s;
      if (clr_i) begin
        err_cnt_r <= mis_s ? ERR_ONE : ERR_ZERO;
      end else if (mis_s && !(&err_cnt_r)) begin
        err_cnt_r <= err_cnt_r + ERR_ONE;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign locked_o  = locked_r;
  assign err_o     = err_r;
  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_prbs4_checker.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the lock/flywheel/error-count rules.
module tb_prbs4_checker;
  import prbs4_pkg::*;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_i = 1'b0;
  logic [3:0] data_i = 4'h0;
  logic       clr_i = 1'b0;
  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_locked, m_seed, m_pulse;
  int m_ref, m_run, m_miss, m_err;

  always #5 clk = ~clk;

  prbs4_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .clr_i(clr_i),
    .locked_o(locked_a), .err_o(err_a), .err_cnt_o(cnt_a));

  prbs4_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .clr_i(clr_i),
    .locked_o(locked_b), .err_o(err_b), .err_cnt_o(cnt_b));

  function automatic int fstep(int s);
    return ((s << 1) & 15) | (((s >> 3) ^ (s >> 1)) & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int d, input bit c);
    bit mis;
    int e;
    mis = 1'b0;
    if (!r) begin
      m_locked = 0; m_seed = 0; m_pulse = 0;
      m_ref = 0; m_run = 0; m_miss = 0; m_err = 0;
      return;
    end
    if (v) begin
      if (!m_locked) begin
        if (m_seed && d == fstep(m_ref) && d != 0) m_run++;
        else m_run = 0;
        m_ref = d;
        m_seed = (d != 0);
        if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
      end else begin
        e = fstep(m_ref);
        m_ref = e;
        if (d != e) begin
          mis = 1'b1;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 0; m_ref = d; m_seed = (d != 0); m_miss = 0; m_run = 0;
          end
        end else m_miss = 0;
      end
    end
    m_pulse = mis;
    if (c) m_err = mis ? 1 : 0;
    else if (mis) m_err++;
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] d, input bit c);
    reset = r; valid_i = v; data_i = d; clr_i = c;
    @(posedge clk);
    model(r, v, int'(d), c);
    #1;
    chk("locked_a", 32'(locked_a), 32'(m_locked));
    chk("err_a", 32'(err_a), 32'(m_pulse));
    chk("cnt_a", 32'(cnt_a), 32'((m_err > 65535) ? 65535 : m_err));
    chk("locked_b", 32'(locked_b), 32'(m_locked));
    chk("err_b", 32'(err_b), 32'(m_pulse));
    chk("cnt_b", 32'(cnt_b), 32'((m_err > 3) ? 3 : m_err));
  endtask

  task automatic word(input logic [3:0] d);
    step(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic lock_seq(input int gap);
    logic [3:0] w;
    w = PRBS4_SEED;
    for (int i = 0; i < 5; i++) begin
      word(w);
      for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 4'hF, 1'b1 ^ 1'b1);
      w = 4'(fstep(int'(w)));
    end
  endtask

  initial begin
    logic [3:0] d;
    bit v, c, r;
    model(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h2, 1'b1);
    chk("reset_locked", 32'(locked_a), 32'd0);
    chk("reset_cnt", 32'(cnt_a), 32'd0);

    // Lock on 2,5,A,4,8
    lock_seq(0);
    chk("lock_after_8", 32'(locked_a), 32'd1);
    chk("lock_cnt0", 32'(cnt_a), 32'd0);

    // Single error inside 1,2,5,F,4,8
    word(4'h1); word(4'h2); word(4'h5); word(4'hF);
    chk("err_pulse_F", 32'(err_a), 32'd1);
    chk("err_cnt_1", 32'(cnt_a), 32'd1);
    word(4'h4);
    chk("err_pulse_once", 32'(err_a), 32'd0);
    word(4'h8);
    chk("still_locked", 32'(locked_a), 32'd1);

    // Three wrong words drop lock, then relock
    word(4'h7); word(4'h7); word(4'h7);
    chk("loss_locked", 32'(locked_a), 32'd0);
    chk("loss_cnt", 32'(cnt_a), 32'd4);
    lock_seq(0);
    chk("relock", 32'(locked_a), 32'd1);

    // All-zero stream never locks
    step(1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) word(4'h0);
    word(4'h2); word(4'h0); word(4'h5);
    chk("zero_no_lock", 32'(locked_a), 32'd0);

    // Gaps are transparent
    step(1'b0, 1'b0, 4'h0, 1'b0);
    lock_seq(3);
    chk("gap_lock", 32'(locked_a), 32'd1);

    // Five isolated errors saturate the narrow counter, then clear
    for (int i = 0; i < 5; i++) begin
      word(4'(fstep(m_ref)) ^ 4'h3);
      word(4'(fstep(m_ref)));
      word(4'(fstep(m_ref)));
    end
    chk("sat_narrow", 32'(cnt_b), 32'd3);
    chk("sat_locked", 32'(locked_b), 32'd1);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    chk("clr_narrow", 32'(cnt_b), 32'd0);
    // clr together with a mismatch leaves a count of one
    word(4'(fstep(m_ref)) ^ 4'h1);
    step(1'b1, 1'b1, 4'(fstep(m_ref)) ^ 4'h1, 1'b1);
    chk("clr_mis_cnt", 32'(cnt_a), 32'd1);
    chk("clr_mis_err", 32'(err_a), 32'd1);
    word(4'(fstep(m_ref)));
    step(1'b0, 1'b1, 4'(fstep(m_ref)) ^ 4'h1, 1'b1);
    chk("midlock_rst", 32'({locked_a, err_a, cnt_a}), 32'd0);

    // Random traffic: mostly on-sequence words, some corruption, clears, resets
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 6) == 0) d = 4'($urandom_range(0, 15));
      else if (!m_seed) d = PRBS4_SEED;
      else d = 4'(fstep(m_ref));
      step(r, v, d, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
